charlie_keypad_scanner: RTL and testbench

Reads a 6-pin charlieplexed switch matrix of 30 keys. It is the input-side counterpart of the charlieplexed LED display driver and uses the same pin/row/column wiring scheme. Each row is driven high in turn, the other five pins are sampled, and every key is debounced over consecutive scans. The block exposes debounced key levels plus a valid/ready event stream of press and release events, consumed by the time-set logic beside the clock counters.

---
 rtl/charlie_pkg.sv | 24 ++
 rtl/charlie_keypad_scanner_key_debounce.sv | 38 +++
 rtl/charlie_keypad_scanner.sv | 139 +++++++++++++
 tb/tb_charlie_keypad_scanner.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/charlie_pkg.sv
// Shared charlieplex constants, scan states and pin mapping.
// Used by the keypad scanner and the LED display driver.
package charlie_pkg;

  localparam int NUM_PINS = 6;
  localparam int NUM_COLS = 5;
  localparam int NUM_KEYS = 30;
  localparam int KEY_W    = 5;

  typedef enum logic [1:0] {
    DISCHARGE,
    DRIVE,
    SAMPLE
  } scan_st_e;

  // Column c of row r sits on pin c, skipping the row's own pin.
  function automatic logic [2:0] col_pin(
    input logic [2:0] row,
    input logic [2:0] col
  );
    return (col < row) ? col : col + 3'd1;
  endfunction

endpackage

// File: rtl/charlie_keypad_scanner_key_debounce.sv
// Per-key debouncer: en strobes one raw sample; state flips after
// DEBOUNCE consecutive differing samples, toggle pulses combinationally.
module key_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw,
  output logic state,
  output logic toggle
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [CW-1:0] cnt;
  logic          hit;

  assign hit    = (cnt == CW'(DEBOUNCE - 1));
  assign toggle = en && (raw != state) && hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= 1'b0;
      cnt   <= '0;
    end else if (en) begin
      if (raw == state) begin
        cnt <= '0;
      end else if (hit) begin
        state <= ~state;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/charlie_keypad_scanner.sv
// Charlieplexed 30-key scanner: pin_oe/pin_out/pin_in pads, keys levels,
// ev_* press/release stream (present only with CHARLIE_KEYPAD_EVENT_EN).
module charlie_keypad_scanner
  import charlie_pkg::*;
#(
  parameter int SETTLE   = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic [NUM_PINS-1:0] pin_oe,
  output logic [NUM_PINS-1:0] pin_out,
  input  logic [NUM_PINS-1:0] pin_in,
  output logic [NUM_KEYS-1:0] keys,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [KEY_W-1:0]    ev_key,
  output logic                ev_press
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  // st is the phase presented on the pins after the next edge;
  // samp marks the cycle currently showing SAMPLE.
  scan_st_e            st;
  logic [2:0]          row;
  logic [SW-1:0]       cnt;
  logic                samp;
  logic [NUM_COLS-1:0] raw;
  logic [NUM_KEYS-1:0] tog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= DISCHARGE;
      row     <= '0;
      cnt     <= '0;
      samp    <= 1'b0;
      pin_oe  <= '0;
      pin_out <= '0;
    end else begin
      unique case (st)
        DISCHARGE: begin
          pin_oe  <= '1;
          pin_out <= '0;
          cnt     <= '0;
          samp    <= 1'b0;
          st      <= DRIVE;
          // Row advances only after a sample, not on the first pass.
          if (samp) row <= (row == 3'd5) ? 3'd0 : row + 3'd1;
        end
        DRIVE: begin
          pin_oe  <= NUM_PINS'(1) << row;
          pin_out <= NUM_PINS'(1) << row;
          if (cnt == SW'(SETTLE - 1)) st <= SAMPLE;
          else cnt <= cnt + SW'(1);
        end
        SAMPLE: begin
          samp <= 1'b1;
          st   <= DISCHARGE;
        end
        default: st <= DISCHARGE;
      endcase
    end
  end

  always_comb begin
    raw = '0;
    for (int c = 0; c < NUM_COLS; c++)
      raw[c] = pin_in[col_pin(row, 3'(c))];
  end

  for (genvar r = 0; r < NUM_PINS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      key_debounce #(
        .DEBOUNCE (DEBOUNCE)
      ) u_db (
        .clk    (clk),
        .rst    (rst),
        .en     (samp && (row == 3'(r))),
        .raw    (raw[c]),
        .state  (keys[r*NUM_COLS+c]),
        .toggle (tog[r*NUM_COLS+c])
      );
    end
  end

`ifdef CHARLIE_KEYPAD_EVENT_EN

  logic [NUM_KEYS-1:0] pend;
  logic [NUM_KEYS-1:0] clr;
  logic [KEY_W-1:0]    pick;
  logic                any;
  logic                ld;

  always_comb begin
    any  = 1'b0;
    pick = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        any  = 1'b1;
        pick = KEY_W'(i);
      end
    end
  end

  assign ld  = !ev_valid || ev_ready;
  assign clr = (ld && any) ? (NUM_KEYS'(1) << pick) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      ev_valid <= 1'b0;
      ev_key   <= '0;
      ev_press <= 1'b0;
    end else begin
      // A second toggle before emission cancels the first.
      pend <= (pend & ~clr) ^ tog;
      if (ld) begin
        ev_valid <= any;
        if (any) begin
          ev_key   <= pick;
          ev_press <= keys[pick];
        end
      end
    end
  end

`else

  logic unused_ev;

  assign unused_ev = ev_ready ^ (^tog);
  assign ev_valid  = 1'b0;
  assign ev_key    = '0;
  assign ev_press  = 1'b0;

`endif

endmodule

// File: tb/tb_charlie_keypad_scanner.sv
// Directed bench for charlie_keypad_scanner, SETTLE=2, DEBOUNCE=3.
// Board model closes switches in "closed" onto the driven row pin.
module tb_charlie_keypad_scanner;

`ifdef CHARLIE_KEYPAD_EVENT_EN
  localparam bit EV = 1'b1;
`else
  localparam bit EV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  pin_oe, pin_out, pin_in;
  logic [29:0] keys;
  logic        ev_valid, ev_ready, ev_press;
  logic [4:0]  ev_key;
  logic [29:0] closed;

  int errs   = 0;
  int checks = 0;
  int cyc    = -1;

  charlie_keypad_scanner #(
    .SETTLE   (2),
    .DEBOUNCE (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pin_oe   (pin_oe),
    .pin_out  (pin_out),
    .pin_in   (pin_in),
    .keys     (keys),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_key   (ev_key),
    .ev_press (ev_press)
  );

  always #5 clk = ~clk;

  always_comb begin
    pin_in = '0;
    for (int r = 0; r < 6; r++)
      if (pin_oe[r] && pin_out[r])
        for (int c = 0; c < 5; c++)
          if (closed[r*5+c])
            pin_in[(c < r) ? c : c + 1] = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic start();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = -1;
  endtask

  task automatic test_reset();
    closed   = '0;
    ev_ready = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({pin_oe, pin_out, keys, ev_valid, ev_key, ev_press} !== '0) begin
      errs++;
      $display("FAIL reset: oe=%h out=%h keys=%h v=%b k=%0d p=%b exp all 0",
               pin_oe, pin_out, keys, ev_valid, ev_key, ev_press);
    end
  endtask

  task automatic test_scan();
    logic [5:0] eoe, eout;
    bit bad;
    closed = '0;
    bad    = 1'b0;
    start();
    for (int k = 0; k < 50; k++) begin
      run_to(k);
      if (k % 4 == 0) begin
        eoe  = 6'h3F;
        eout = 6'h00;
      end else begin
        eoe  = 6'd1 << ((k / 4) % 6);
        eout = eoe;
      end
      checks++;
      if (pin_oe !== eoe || pin_out !== eout) begin
        errs++;
        $display("FAIL scan c%0d: oe=%h out=%h exp oe=%h out=%h",
                 k, pin_oe, pin_out, eoe, eout);
      end
      if (keys !== '0 || ev_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errs++;
      $display("FAIL scan_idle: keys/ev_valid nonzero, exp 0");
    end
  endtask

  task automatic test_press();
    closed    = '0;
    closed[7] = 1'b1;
    ev_ready  = 1'b0;
    start();
    run_to(55);
    checks++;
    if (keys[7] !== 1'b0 || ev_valid !== 1'b0) begin
      errs++;
      $display("FAIL press_pre: k7=%b v=%b exp 0 0", keys[7], ev_valid);
    end
    run_to(56);
    checks++;
    if (keys !== 30'h80 || ev_valid !== 1'b0) begin
      errs++;
      $display("FAIL press_keys: keys=%h v=%b exp 80 0", keys, ev_valid);
    end
    run_to(57);
    checks++;
    if (ev_valid !== EV || ev_key !== (EV ? 5'd7 : 5'd0) ||
        ev_press !== EV) begin
      errs++;
      $display("FAIL press_ev: v=%b k=%0d p=%b exp %b %0d %b",
               ev_valid, ev_key, ev_press, EV, EV ? 7 : 0, EV);
    end
    ev_ready = 1'b1;
    run_to(58);
    ev_ready  = 1'b0;
    closed[7] = 1'b0;
    checks++;
    if (ev_valid !== 1'b0) begin
      errs++;
      $display("FAIL press_xfer: v=%b exp 0", ev_valid);
    end
    run_to(127);
    checks++;
    if (keys[7] !== 1'b1) begin
      errs++;
      $display("FAIL rel_pre: k7=%b exp 1", keys[7]);
    end
    run_to(128);
    checks++;
    if (keys !== '0 || ev_valid !== 1'b0) begin
      errs++;
      $display("FAIL rel_keys: keys=%h v=%b exp 0 0", keys, ev_valid);
    end
    run_to(129);
    checks++;
    if (ev_valid !== EV || ev_key !== (EV ? 5'd7 : 5'd0) ||
        ev_press !== 1'b0) begin
      errs++;
      $display("FAIL rel_ev: v=%b k=%0d p=%b exp %b %0d 0",
               ev_valid, ev_key, ev_press, EV, EV ? 7 : 0);
    end
  endtask

  task automatic test_bounce();
    bit bad;
    bad       = 1'b0;
    closed    = '0;
    closed[7] = 1'b1;
    ev_ready  = 1'b0;
    start();
    for (int k = 0; k <= 140; k++) begin
      run_to(k);
      if (k == 40)  closed[7] = 1'b0;
      if (k == 60)  closed[7] = 1'b1;
      if (k == 110) closed[7] = 1'b0;
      if (keys !== '0 || ev_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errs++;
      $display("FAIL bounce: keys=%h v=%b exp no change", keys, ev_valid);
    end
  endtask

  task automatic test_back_to_back();
    closed    = '0;
    closed[5] = 1'b1;
    closed[9] = 1'b1;
    ev_ready  = 1'b0;
    start();
    run_to(56);
    checks++;
    if (keys !== 30'h220 || ev_valid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_keys: keys=%h v=%b exp 220 0", keys, ev_valid);
    end
    for (int k = 57; k <= 60; k++) begin
      run_to(k);
      checks++;
      if (ev_valid !== EV || ev_key !== (EV ? 5'd5 : 5'd0) ||
          ev_press !== EV) begin
        errs++;
        $display("FAIL b2b_hold c%0d: v=%b k=%0d p=%b exp %b %0d %b",
                 k, ev_valid, ev_key, ev_press, EV, EV ? 5 : 0, EV);
      end
    end
    ev_ready = 1'b1;
    run_to(61);
    checks++;
    if (ev_valid !== EV || ev_key !== (EV ? 5'd9 : 5'd0) ||
        ev_press !== EV) begin
      errs++;
      $display("FAIL b2b_second: v=%b k=%0d p=%b exp %b %0d %b",
               ev_valid, ev_key, ev_press, EV, EV ? 9 : 0, EV);
    end
    run_to(62);
    ev_ready = 1'b0;
    checks++;
    if (ev_valid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_empty: v=%b exp 0", ev_valid);
    end
  endtask

  task automatic test_cancel();
    closed     = '0;
    closed[0]  = 1'b1;
    closed[12] = 1'b1;
    ev_ready   = 1'b0;
    start();
    run_to(60);
    closed[12] = 1'b0;
    checks++;
    if (keys !== 30'h1001) begin
      errs++;
      $display("FAIL cancel_set: keys=%h exp 1001", keys);
    end
    run_to(132);
    checks++;
    if (keys !== 30'h1) begin
      errs++;
      $display("FAIL cancel_clr: keys=%h exp 1", keys);
    end
    run_to(133);
    checks++;
    if (ev_valid !== EV || ev_key !== 5'd0 || ev_press !== EV) begin
      errs++;
      $display("FAIL cancel_hold: v=%b k=%0d p=%b exp %b 0 %b",
               ev_valid, ev_key, ev_press, EV, EV);
    end
    ev_ready = 1'b1;
    run_to(134);
    checks++;
    if (ev_valid !== 1'b0) begin
      errs++;
      $display("FAIL cancel_none: v=%b k=%0d exp v=0",
               ev_valid, ev_key);
    end
    run_to(140);
    ev_ready = 1'b0;
    checks++;
    if (ev_valid !== 1'b0) begin
      errs++;
      $display("FAIL cancel_late: v=%b k=%0d exp v=0",
               ev_valid, ev_key);
    end
  endtask

  task automatic test_reset_mid();
    closed    = '0;
    closed[0] = 1'b1;
    ev_ready  = 1'b0;
    start();
    run_to(61);
    checks++;
    if (pin_oe !== 6'h08 || ev_valid !== EV || keys !== 30'h1) begin
      errs++;
      $display("FAIL mid_pre: oe=%h v=%b keys=%h exp 08 %b 1",
               pin_oe, ev_valid, keys, EV);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({pin_oe, pin_out, keys, ev_valid, ev_key, ev_press} !== '0) begin
      errs++;
      $display("FAIL mid_async: oe=%h out=%h keys=%h v=%b k=%0d p=%b exp 0",
               pin_oe, pin_out, keys, ev_valid, ev_key, ev_press);
    end
    closed = '0;
    @(negedge clk);
    rst = 1'b0;
    cyc = -1;
    run_to(0);
    checks++;
    if (pin_oe !== 6'h3F || pin_out !== 6'h00 || ev_valid !== 1'b0) begin
      errs++;
      $display("FAIL mid_c0: oe=%h out=%h v=%b exp 3f 00 0",
               pin_oe, pin_out, ev_valid);
    end
    run_to(1);
    checks++;
    if (pin_oe !== 6'h01 || pin_out !== 6'h01) begin
      errs++;
      $display("FAIL mid_c1: oe=%h out=%h exp 01 01", pin_oe, pin_out);
    end
  endtask

  initial begin
    closed   = '0;
    ev_ready = 1'b0;
    test_reset();
    test_scan();
    test_press();
    test_bounce();
    test_back_to_back();
    test_cancel();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
